// File: rtl/bayer_wb_pkg.sv
// Shared Bayer-domain encodings and helpers for the white-balance stage.
package bayer_wb_pkg;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } bayer_pat_e;

  typedef enum logic [1:0] {
    CH_R  = 2'd0,
    CH_GR = 2'd1,
    CH_GB = 2'd2,
    CH_B  = 2'd3
  } bayer_chan_e;

  // Input-to-output latency of the gain pipeline, in clock cycles.
  localparam int unsigned PIPE_LAT = 3;

  // Unity gain for an unsigned fixed-point gain with gain_frac fractional bits.
  function automatic int unsigned unity_gain(input int unsigned gain_frac);
    return 32'd1 << gain_frac;
  endfunction

endpackage

// File: rtl/bayer_pos_tracker.sv
// Tracks horizontal position and row/column parity of a Bayer stream and
// reports the colour channel of the pixel currently presented.
module bayer_pos_tracker
  import bayer_wb_pkg::*;
#(
  parameter int unsigned H_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_i,
  input  logic           sof_i,
  input  logic [H_W-1:0] h_active_i,
  input  logic [1:0]     pattern_i,
  output logic [1:0]     chan_c_o
);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic           col_q, col_d;
  logic           row_q, row_d;
  logic [H_W-1:0] h_eff_c;
  logic           col_eff_c;
  logic           row_eff_c;
  logic           restart_c;

  // A start-of-frame pixel sits at the origin regardless of tracked position.
  always_comb begin
    restart_c = valid_i & sof_i;
    h_eff_c   = restart_c ? '0   : h_cnt_q;
    col_eff_c = restart_c ? 1'b0 : col_q;
    row_eff_c = restart_c ? 1'b0 : row_q;
    chan_c_o  = {row_eff_c ^ pattern_i[1], col_eff_c ^ pattern_i[0]};
  end

  // Next position: advance per valid pixel, wrap at end of active line.
  always_comb begin
    h_cnt_d = h_cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    if (valid_i) begin
      if (h_eff_c == h_active_i - H_W'(1)) begin
        h_cnt_d = '0;
        col_d   = 1'b0;
        row_d   = ~row_eff_c;
      end else begin
        h_cnt_d = h_eff_c + H_W'(1);
        col_d   = ~col_eff_c;
        row_d   = row_eff_c;
      end
    end
  end

  // Position state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      col_q   <= 1'b0;
      row_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/bayer_wb_gain.sv
// Bayer white-balance gain: per-channel fixed-point gain with rounding,
// saturation, frame-synchronous config shadowing, bypass and clip counting.
module bayer_wb_gain
  import bayer_wb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = 6,
  parameter int unsigned H_W       = 11,
  parameter int unsigned CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_pattern,
  input  logic              cfg_bypass,
  input  logic [GAIN_W-1:0] cfg_gain_r,
  input  logic [GAIN_W-1:0] cfg_gain_gr,
  input  logic [GAIN_W-1:0] cfg_gain_gb,
  input  logic [GAIN_W-1:0] cfg_gain_b,
  input  logic [H_W-1:0]    cfg_h_active,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  sat_count,
  output logic              sat_count_vld
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_FRAC));
  localparam logic [SUM_W-1:0]  HALF_LSB = SUM_W'(1) << (GAIN_FRAC - 1);
  localparam logic [SUM_W-1:0]  PIX_MAX  = SUM_W'({DATA_W{1'b1}});

  // Config shadow, loaded on every start-of-frame pixel
  logic [1:0]              pat_q;
  logic                    byp_q;
  logic [3:0][GAIN_W-1:0]  gain_q;

  logic                    sof_px_c;
  logic [1:0]              pat_c;
  logic                    byp_c;
  logic [3:0][GAIN_W-1:0]  gain_live_c;
  logic [3:0][GAIN_W-1:0]  gain_c;
  logic [1:0]              chan_c;
  logic [GAIN_W-1:0]       gain_sel_c;

  // Pipeline sideband and stage data
  logic [PIPE_LAT-1:0]     vld_q;
  logic [PIPE_LAT-1:0]     sof_q;
  logic [DATA_W-1:0]       s1_data_q;
  logic [GAIN_W-1:0]       s1_gain_q;
  logic                    s1_byp_q;
  logic [PROD_W-1:0]       s2_prod_q;
  logic [DATA_W-1:0]       s2_data_q;
  logic                    s2_byp_q;
  logic [DATA_W-1:0]       out_data_q;
  logic                    out_clip_q;

  logic [SUM_W-1:0]        sum_c;
  logic [SUM_W-1:0]        res_c;
  logic                    clip_c;
  logic [DATA_W-1:0]       gained_c;

  // Saturation accounting
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        sat_q, sat_d;
  logic                    sat_vld_q, sat_vld_d;

  // The sof pixel sees live config; all others see the shadow.
  always_comb begin
    sof_px_c    = in_valid & in_sof;
    gain_live_c = {cfg_gain_b, cfg_gain_gb, cfg_gain_gr, cfg_gain_r};
    pat_c       = sof_px_c ? cfg_pattern : pat_q;
    byp_c       = sof_px_c ? cfg_bypass  : byp_q;
    gain_c      = sof_px_c ? gain_live_c : gain_q;
    gain_sel_c  = gain_c[chan_c];
  end

  bayer_pos_tracker #(
    .H_W (H_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (in_valid),
    .sof_i      (in_sof),
    .h_active_i (cfg_h_active),
    .pattern_i  (pat_c),
    .chan_c_o   (chan_c)
  );

  // Shadow registers; reset to bypass so pre-frame pixels pass unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_RGGB;
      byp_q  <= 1'b1;
      gain_q <= {4{UNITY}};
    end else if (sof_px_c) begin
      pat_q  <= cfg_pattern;
      byp_q  <= cfg_bypass;
      gain_q <= gain_live_c;
    end
  end

  // Valid/sof delay line matching the datapath depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sof_q <= '0;
    end else begin
      vld_q <= {vld_q[PIPE_LAT-2:0], in_valid};
      sof_q <= {sof_q[PIPE_LAT-2:0], sof_px_c};
    end
  end

  // S1: capture pixel, its channel gain and bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q <= '0;
      s1_gain_q <= '0;
      s1_byp_q  <= 1'b0;
    end else if (in_valid) begin
      s1_data_q <= in_data;
      s1_gain_q <= gain_sel_c;
      s1_byp_q  <= byp_c;
    end
  end

  // S2: full-precision product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_prod_q <= '0;
      s2_data_q <= '0;
      s2_byp_q  <= 1'b0;
    end else if (vld_q[0]) begin
      s2_prod_q <= PROD_W'(s1_data_q) * PROD_W'(s1_gain_q);
      s2_data_q <= s1_data_q;
      s2_byp_q  <= s1_byp_q;
    end
  end

  // Round half-up, drop fraction bits, clamp to pixel range.
  always_comb begin
    sum_c    = SUM_W'(s2_prod_q) + HALF_LSB;
    res_c    = sum_c >> GAIN_FRAC;
    clip_c   = (res_c > PIX_MAX);
    gained_c = clip_c ? {DATA_W{1'b1}} : res_c[DATA_W-1:0];
  end

  // S3: output register; bypassed pixels are never flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_clip_q <= 1'b0;
    end else if (vld_q[1]) begin
      out_data_q <= s2_byp_q ? s2_data_q : gained_c;
      out_clip_q <= ~s2_byp_q & clip_c;
    end
  end

  // Per-frame clip count: report and restart on each output sof beat.
  always_comb begin
    acc_d     = acc_q;
    sat_d     = sat_q;
    sat_vld_d = 1'b0;
    if (vld_q[PIPE_LAT-1] && sof_q[PIPE_LAT-1]) begin
      sat_d     = acc_q;
      sat_vld_d = 1'b1;
      acc_d     = out_clip_q ? CNT_W'(1) : '0;
    end else if (vld_q[PIPE_LAT-1] && out_clip_q && (acc_q != {CNT_W{1'b1}})) begin
      acc_d     = acc_q + CNT_W'(1);
    end
  end

  // Saturation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sat_q     <= '0;
      sat_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      sat_vld_q <= sat_vld_d;
    end
  end

  assign out_valid     = vld_q[PIPE_LAT-1];
  assign out_sof       = sof_q[PIPE_LAT-1];
  assign out_data      = out_data_q;
  assign sat_count     = sat_q;
  assign sat_count_vld = sat_vld_q;

endmodule
